// File: rtl/instr_encoder.sv
// RV32I instruction encoder and IMEM loader: packs field bundles into 32-bit words and writes them
// sequentially through a single-word acked port. Optional immediate range check: IMM_CHECK_EN.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enc_valid,
  output logic          enc_ready,
  input  logic [3:0]    iclass,
  input  logic [2:0]    funct3,
  input  logic          funct7b5,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [31:0]   imm,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_ack,
  output logic          enc_err,
  output logic          full,
  output logic [CW-1:0] count
);

  typedef enum logic [1:0] {StIdle, StEnc, StWr} state_e;

  localparam logic [3:0] ClsLw    = 4'd0;
  localparam logic [3:0] ClsSw    = 4'd1;
  localparam logic [3:0] ClsR     = 4'd2;
  localparam logic [3:0] ClsBr    = 4'd3;
  localparam logic [3:0] ClsIalu  = 4'd4;
  localparam logic [3:0] ClsJal   = 4'd5;
  localparam logic [3:0] ClsJalr  = 4'd6;
  localparam logic [3:0] ClsLui   = 4'd7;
  localparam logic [3:0] ClsAuipc = 4'd8;

  state_e        state_q, state_d;
  logic [3:0]    cls_q;
  logic [2:0]    f3_q;
  logic          f7b5_q;
  logic [4:0]    rd_q, rs1_q, rs2_q;
  logic [31:0]   imm_q;
  logic [31:0]   wdata_q;
  logic [31:0]   addr_q;
  logic [CW-1:0] count_q;
  logic          err_q;

  logic [31:0]   word;
  logic          cls_ok;
  logic          drop;
  logic          accept;
  logic          is_shift;

  assign full       = (count_q == CW'(DEPTH));
  assign enc_ready  = (state_q == StIdle) && !full && !clear;
  assign accept     = enc_valid && enc_ready;
  assign imem_we    = (state_q == StWr);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign enc_err    = err_q;
  assign count      = count_q;
  assign is_shift   = (f3_q == 3'b001) || (f3_q == 3'b101);

  always_comb begin
    word   = '0;
    cls_ok = 1'b1;
    case (cls_q)
      ClsLw:    word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
      ClsSw:    word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
      ClsR:     word = {1'b0, f7b5_q, 5'b00000, rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
      ClsBr:    word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11],
                        7'b1100011};
      ClsIalu: begin
        if (is_shift) begin
          word = {1'b0, f7b5_q, 5'b00000, imm_q[4:0], rs1_q, f3_q, rd_q, 7'b0010011};
        end else begin
          word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0010011};
        end
      end
      ClsJal:   word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
      ClsJalr:  word = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b1100111};
      ClsLui:   word = {imm_q[31:12], rd_q, 7'b0110111};
      ClsAuipc: word = {imm_q[31:12], rd_q, 7'b0010111};
      default:  cls_ok = 1'b0;
    endcase
  end

`ifdef IMM_CHECK_EN
  logic fits12, fits13, fits21, imm_ok;
  // Signed N-bit fit: all bits from N-1 upward equal the sign.
  assign fits12 = (&imm_q[31:11]) || !(|imm_q[31:11]);
  assign fits13 = (&imm_q[31:12]) || !(|imm_q[31:12]);
  assign fits21 = (&imm_q[31:20]) || !(|imm_q[31:20]);

  always_comb begin
    imm_ok = 1'b1;
    case (cls_q)
      ClsLw, ClsSw, ClsJalr: imm_ok = fits12;
      ClsIalu:               imm_ok = is_shift ? !(|imm_q[31:5]) : fits12;
      ClsBr:                 imm_ok = fits13 && !imm_q[0];
      ClsJal:                imm_ok = fits21 && !imm_q[0];
      ClsLui, ClsAuipc:      imm_ok = !(|imm_q[11:0]);
      default:               imm_ok = 1'b1;
    endcase
  end

  assign drop = !cls_ok || !imm_ok;
`else
  assign drop = !cls_ok;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StEnc;
      StEnc:   state_d = drop ? StIdle : StWr;
      StWr:    if (imem_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_q   <= '0;
      f3_q    <= '0;
      f7b5_q  <= 1'b0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      wdata_q <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      // Clear outranks a same-cycle ack, so an in-flight write is never counted.
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state_q == StEnc) && drop;
      if (accept) begin
        cls_q  <= iclass;
        f3_q   <= funct3;
        f7b5_q <= funct7b5;
        rd_q   <= rd;
        rs1_q  <= rs1;
        rs2_q  <= rs2;
        imm_q  <= imm;
      end
      if ((state_q == StEnc) && !drop) begin
        wdata_q <= word;
      end
      if ((state_q == StWr) && imem_ack) begin
        addr_q  <= addr_q + 32'd4;
        count_q <= count_q + CW'(1);
      end
    end
  end

endmodule
